sonar_scheduler: RTL
====================

// Module: sonar_scheduler
// PURPOSE
//  Time-multiplexed controller for the two ultrasonic rangers (echo1/echo2).
//  Fires one sensor at a time so their bursts never cross-talk, measures the
//  echo width, converts it to centimetres and publishes per-channel results
//  with valid/timeout strobes. Feeds the occupancy counter logic.
// PARAMETERS
//  TICKS_PER_US  50     CLK cycles per microsecond (50 MHz board clock)
//  TRIG_US       10     trigger pulse width, us
//  RISE_TO_US    30000  max wait from trig fall to echo rise, us
//  ECHO_TO_US    25000  max echo high time, us (~431 cm)
//  SETTLE_US     10000  dead time after each measurement before next channel
//  US_PER_CM     58     echo microseconds per centimetre
// PORTS
//  CLK       in   1  system clock, all logic on posedge
//  RST       in   1  synchronous, active-high reset
//  enable    in   1  1 = keep scheduling measurements
//  echo1     in   1  sensor 1 echo, asynchronous
//  echo2     in   1  sensor 2 echo, asynchronous
//  trig1     out  1  sensor 1 trigger, registered
//  trig2     out  1  sensor 2 trigger, registered
//  dist1     out  9  last sensor 1 distance, cm, saturating at 511
//  dist2     out  9  last sensor 2 distance, cm, saturating at 511
//  valid1    out  1  1-cycle strobe: dist1 updated with good measurement
//  valid2    out  1  1-cycle strobe: dist2 updated with good measurement
//  tmo1      out  1  1-cycle strobe: sensor 1 measurement timed out
//  tmo2      out  1  1-cycle strobe: sensor 2 measurement timed out
//  busy      out  1  1 whenever FSM is not IDLE
// BEHAVIOUR
//  Reset: all outputs 0, dist1/dist2 = 0, FSM=IDLE, ch=0 (sensor 1), counters 0.
//  Echo inputs pass a 2-flop synchroniser; edges detected on synced signal.
//  Shared us prescaler counts 0..TICKS_PER_US-1, cleared on every state entry.
//  FSM (one channel ch active; other channel's echo ignored):
//   IDLE:   enable=1 -> TRIG.
//   TRIG:   trig[ch]=1 for exactly TRIG_US*TICKS_PER_US cycles, then WAIT_RISE.
//   WAIT_RISE: echo rise -> MEASURE (us and cm counters cleared);
//           RISE_TO_US elapsed -> tmo[ch] strobe, dist unchanged, -> SETTLE.
//   MEASURE: us counter +1 per us tick; cm counter +1 every US_PER_CM us,
//           saturating at 511. Echo fall -> dist[ch]<=cm, valid[ch] strobe
//           (cycle after fall seen), -> SETTLE. ECHO_TO_US elapsed with echo
//           high -> dist[ch]<=511, tmo[ch] strobe, -> SETTLE.
//   SETTLE: wait SETTLE_US; then ch<=~ch; enable ? TRIG : IDLE.
//  dist = floor(echo_us/58); residual partial us/cm at fall is discarded.
//  Echo already high on WAIT_RISE entry (stuck sensor) is not a rise; waits
//  for 0->1 edge or times out.
//  enable low mid-cycle: current measurement completes through SETTLE, then
//  IDLE; no truncated trig pulse ever produced.
//  RST mid-operation: trig forced 0 at that edge, no strobes, ch back to 0.
//  valid and tmo for one channel never assert in the same cycle; never both
//  channels' strobes in same cycle.
//  Round-robin strict: channel order 1,2,1,2... regardless of timeouts.
// TESTING (sim params TICKS_PER_US=2, TRIG_US=10, RISE_TO_US=200,
//  ECHO_TO_US=1200, SETTLE_US=50)
//  1 Reset then enable=1 -> trig1 high exactly 20 cycles, trig2 stays 0.
//  2 echo1 high 580 us after trig1 -> valid1 once, dist1=10; then trig2 fires
//    after 50 us settle.
//  3 echo2 high 1160 us -> dist2=20, valid2; echo1 toggled meanwhile: no effect.
//  4 echo1 never rises -> tmo1 strobe 200 us after trig1 fall, dist1 keeps 10.
//  5 echo2 stuck high 1500 us -> tmo2 at 1200 us, dist2=511, no valid2.
//  6 enable=0 during MEASURE -> result still posted, FSM IDLE after settle,
//    busy=0; RST pulse during TRIG -> trig low next edge, all outputs 0.

Source files
------------

// File: rtl/sonar_scheduler.sv
// Two-channel ultrasonic ranger scheduler: fires sensor 1 and sensor 2 alternately,
// times each echo pulse, converts it to centimetres and publishes per-channel strobes.
module sonar_scheduler #(
    parameter int TICKS_PER_US = 50,
    parameter int TRIG_US      = 10,
    parameter int RISE_TO_US   = 30000,
    parameter int ECHO_TO_US   = 25000,
    parameter int SETTLE_US    = 10000,
    parameter int US_PER_CM    = 58
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic       echo1,
    input  logic       echo2,
    output logic       trig1,
    output logic       trig2,
    output logic [8:0] dist1,
    output logic [8:0] dist2,
    output logic       valid1,
    output logic       valid2,
    output logic       tmo1,
    output logic       tmo2,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_SETTLE
    } state_e;

    localparam int TW = $clog2(TICKS_PER_US + 1);
    localparam int CW = $clog2(US_PER_CM + 1);

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS_PER_US - 1);
    localparam logic [CW-1:0] CM_LAST     = CW'(US_PER_CM - 1);
    localparam logic [15:0]   TRIG_LAST   = 16'(TRIG_US - 1);
    localparam logic [15:0]   RISE_LAST   = 16'(RISE_TO_US - 1);
    localparam logic [15:0]   ECHO_LAST   = 16'(ECHO_TO_US - 1);
    localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE_US - 1);

    state_e        state_q, state_d;
    logic          ch_q, ch_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [15:0]   us_q, us_d;
    logic [CW-1:0] sub_q, sub_d;
    logic [8:0]    cm_q, cm_d;
    logic [1:0]    meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;
    logic [1:0]    trig_q, trig_d, valid_q, valid_d, tmo_q, tmo_d;
    logic [8:0]    dist1_q, dist1_d, dist2_q, dist2_d;

    logic          us_tick, echo_s, echo_p, rise, fall;
    logic [CW-1:0] sub_nxt;
    logic [8:0]    cm_nxt;

    assign us_tick = (tick_q == TICK_LAST);
    assign echo_s  = sync_q[ch_q];
    assign echo_p  = prev_q[ch_q];
    assign rise    = echo_s & ~echo_p;
    assign fall    = ~echo_s & echo_p;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        dist1_d = dist1_q;
        dist2_d = dist2_q;
        valid_d = 2'b00;
        tmo_d   = 2'b00;
        meta_d  = {echo2, echo1};
        sync_d  = meta_q;
        prev_d  = sync_q;

        // Count in the current cycle too, so an echo of exactly N*US_PER_CM us yields N cm.
        sub_nxt = sub_q;
        cm_nxt  = cm_q;
        if (us_tick) begin
            if (sub_q == CM_LAST) begin
                sub_nxt = '0;
                if (cm_q != 9'd511) cm_nxt = cm_q + 9'd1;
            end else begin
                sub_nxt = sub_q + CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_TRIG;
            end
            S_TRIG: begin
                if (us_tick && us_q == TRIG_LAST) state_d = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (rise) begin
                    state_d = S_MEASURE;
                end else if (us_tick && us_q == RISE_LAST) begin
                    tmo_d[ch_q] = 1'b1;
                    state_d     = S_SETTLE;
                end
            end
            S_MEASURE: begin
                sub_d = sub_nxt;
                cm_d  = cm_nxt;
                if (fall) begin
                    if (ch_q) dist2_d = cm_nxt;
                    else      dist1_d = cm_nxt;
                    valid_d[ch_q] = 1'b1;
                    state_d       = S_SETTLE;
                end else if (us_tick && us_q == ECHO_LAST) begin
                    if (ch_q) dist2_d = 9'd511;
                    else      dist1_d = 9'd511;
                    tmo_d[ch_q] = 1'b1;
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (us_tick && us_q == SETTLE_LAST) begin
                    ch_d    = ~ch_q;
                    state_d = enable ? S_TRIG : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            tick_d = '0;
            us_d   = '0;
            sub_d  = '0;
            cm_d   = '0;
        end else begin
            tick_d = us_tick ? '0 : tick_q + TW'(1);
            us_d   = us_tick ? us_q + 16'd1 : us_q;
        end

        // Trigger follows the registered state, so its width equals the TRIG dwell exactly.
        trig_d = 2'b00;
        if (state_d == S_TRIG) trig_d[ch_d] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ch_q    <= 1'b0;
            tick_q  <= '0;
            us_q    <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
            meta_q  <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            trig_q  <= '0;
            valid_q <= '0;
            tmo_q   <= '0;
            dist1_q <= '0;
            dist2_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            tick_q  <= tick_d;
            us_q    <= us_d;
            sub_q   <= sub_d;
            cm_q    <= cm_d;
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            trig_q  <= trig_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
            dist1_q <= dist1_d;
            dist2_q <= dist2_d;
        end
    end

    // Result strobes are single-cycle, no handshake: dist is stable in the strobe cycle.
    assign trig1  = trig_q[0];
    assign trig2  = trig_q[1];
    assign valid1 = valid_q[0];
    assign valid2 = valid_q[1];
    assign tmo1   = tmo_q[0];
    assign tmo2   = tmo_q[1];
    assign dist1  = dist1_q;
    assign dist2  = dist2_q;
    assign busy   = (state_q != S_IDLE);

endmodule
